// File: rtl/dadda_final_adder_pipe.sv
// Final carry-propagate adder of the pipelined 8x8 Dadda multiplier.
// Two valid/ready stages: low SPLIT bits first, then the high bits plus the registered carry.
module dadda_final_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int SPLIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Row_A,
    input  logic [WIDTH-1:0] Row_B,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Product,
    output logic             Ovf
);

    localparam int HW = WIDTH - SPLIT;

    logic             s1_v;
    logic [SPLIT-1:0] s1_lo;
    logic             s1_c;
    logic [HW-1:0]    s1_ah;
    logic [HW-1:0]    s1_bh;
    logic             s2_v;

    logic             s2_adv;
    logic             accept;
    logic [SPLIT:0]   lo_sum;
    logic [HW:0]      hi_sum;

    // Ready is purely combinational so a draining output frees both stages in the same cycle.
    assign s2_adv    = ~s2_v | Out_Ready;
    assign In_Ready  = ~s1_v | s2_adv;
    assign accept    = In_Valid & In_Ready;
    assign Out_Valid = s2_v;

    assign lo_sum = {1'b0, Row_A[SPLIT-1:0]} + {1'b0, Row_B[SPLIT-1:0]};
    assign hi_sum = {1'b0, s1_ah} + {1'b0, s1_bh} + {{HW{1'b0}}, s1_c};

    // Data registers load only on a real transfer, so idle inputs never reach the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_lo   <= '0;
            s1_c    <= 1'b0;
            s1_ah   <= '0;
            s1_bh   <= '0;
            s2_v    <= 1'b0;
            Product <= '0;
            Ovf     <= 1'b0;
        end else begin
            if (In_Ready) begin
                s1_v <= In_Valid;
            end
            if (accept) begin
                {s1_c, s1_lo} <= lo_sum;
                s1_ah         <= Row_A[WIDTH-1:SPLIT];
                s1_bh         <= Row_B[WIDTH-1:SPLIT];
            end
            if (s2_adv) begin
                s2_v <= s1_v ? 1'b1 : (Out_Ready ? 1'b0 : s2_v);
            end
            if (s1_v && s2_adv) begin
                {Ovf, Product[WIDTH-1:SPLIT]} <= hi_sum;
                Product[SPLIT-1:0]            <= s1_lo;
            end
        end
    end

endmodule

// File: tb/tb_dadda_final_adder_pipe.sv
// Scoreboard bench for dadda_final_adder_pipe: expected sums queued on accept,
// popped and compared whenever an output beat is consumed.
module tb_dadda_final_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        In_Valid;
    logic        In_Ready;
    logic [15:0] Row_A;
    logic [15:0] Row_B;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [15:0] Product;
    logic        Ovf;

    logic [16:0] sb[$];
    int          total = 0;
    int          bad = 0;
    int          popCount = 0;
    bit          lastAccept;
    bit          cSent;

    dadda_final_adder_pipe #(.WIDTH(16), .SPLIT(8)) dut (
        .clk(clk),
        .rst(rst),
        .In_Valid(In_Valid),
        .In_Ready(In_Ready),
        .Row_A(Row_A),
        .Row_B(Row_B),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready),
        .Product(Product),
        .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic [16:0] exp;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("[TB] FAIL unexpected_beat got=%h expected=no_beat", {Ovf, Product});
        end
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            popCount++;
            total++;
            assert ({Ovf, Product} === exp) else begin
                bad++;
                $error("[TB] FAIL result got=%h expected=%h", {Ovf, Product}, exp);
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, observe transfers, then cross the rising edge.
    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic ordy);
        logic [16:0] exp;
        In_Valid  = v;
        Row_A     = v ? a : 16'($urandom);
        Row_B     = v ? b : 16'($urandom);
        Out_Ready = ordy;
        #1;
        lastAccept = In_Valid && In_Ready;
        if (Out_Valid && Out_Ready) checkOutput();
        if (lastAccept) begin
            exp = 17'(a) + 17'(b);
            sb.push_back(exp);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && sb.size() > 0; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        expectEq("drain_empty", sb.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        In_Valid  = 1'b0;
        Row_A     = 16'h0;
        Row_B     = 16'h0;
        Out_Ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expectEq("rst_out_valid", Out_Valid, 0);
        expectEq("rst_in_ready", In_Ready, 1);
        expectEq("rst_product", Product, 0);
        expectEq("rst_ovf", Ovf, 0);

        $display("[TB] 255*255 latency");
        applyStimulus(1'b1, 16'hFE00, 16'h0001, 1'b1);
        expectEq("t1_valid_cycle1", Out_Valid, 0);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        expectEq("t1_valid_cycle2", Out_Valid, 1);
        expectEq("t1_product", Product, 16'hFE01);
        expectEq("t1_ovf", Ovf, 0);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        expectEq("t1_single_beat", Out_Valid, 0);

        $display("[TB] split carry and overflow");
        applyStimulus(1'b1, 16'h00FF, 16'h0001, 1'b1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        expectEq("t2_product", Product, 16'h0100);
        drain();
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        expectEq("t3_product", Product, 16'h0000);
        expectEq("t3_ovf", Ovf, 1);
        drain();

        $display("[TB] back-to-back stream");
        popCount = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(i * 257), 16'(i), 1'b1);
        expectEq("t4_pops_in_stream", popCount, 6);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        expectEq("t4_all_out", sb.size(), 0);
        expectEq("t4_pop_total", popCount, 8);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 16'h12F0, 16'h0020, 1'b0);
        applyStimulus(1'b1, 16'h80FF, 16'h8001, 1'b0);
        expectEq("t5_in_ready_low", In_Ready, 0);
        expectEq("t5_out_valid", Out_Valid, 1);
        expectEq("t5_head_product", Product, 16'h1310);
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        expectEq("t5_c_blocked", lastAccept, 0);
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        expectEq("t5_product_hold", Product, 16'h1310);
        expectEq("t5_ovf_hold", Ovf, 0);
        cSent = 1'b0;
        for (int i = 0; i < 10 && (sb.size() > 0 || !cSent); i++) begin
            applyStimulus(!cSent, 16'h7FFF, 16'h0001, 1'b1);
            if (lastAccept) cSent = 1'b1;
        end
        expectEq("t5_c_sent", cSent, 1);
        expectEq("t5_all_out", sb.size(), 0);

        $display("[TB] reset with both stages full");
        applyStimulus(1'b1, 16'hAAAA, 16'h5555, 1'b0);
        applyStimulus(1'b1, 16'h0F0F, 16'hF0F1, 1'b0);
        expectEq("t6_full", Out_Valid, 1);
        rst      = 1'b1;
        In_Valid = 1'b1;
        Row_A    = 16'h1111;
        Row_B    = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        In_Valid = 1'b0;
        sb.delete();
        #1;
        expectEq("t6_out_valid", Out_Valid, 0);
        expectEq("t6_product", Product, 0);
        expectEq("t6_ovf", Ovf, 0);
        expectEq("t6_in_ready", In_Ready, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
            expectEq("t6_no_stale", Out_Valid, 0);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++)
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
